// File: rtl/lbp_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbp_pkg
// Purpose  : Shared types and constants for the streaming 3x3 LBP engine:
//            FSM state encoding, LBP bit positions and the neighbour
//            comparison helper.
// Revision : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit position of each neighbour inside the 8-bit LBP code
    localparam int B_TL = 0;
    localparam int B_T  = 1;
    localparam int B_TR = 2;
    localparam int B_L  = 3;
    localparam int B_R  = 4;
    localparam int B_BL = 5;
    localparam int B_B  = 6;
    localparam int B_BR = 7;

    // Unsigned neighbour-vs-centre test; operands arrive zero-extended
    function automatic logic nb_bit(input logic [31:0] nb,
                                    input logic [31:0] ctr,
                                    input logic        strict);
        return strict ? (nb > ctr) : (nb >= ctr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : lbp_stream_if
// Purpose  : Memory-side bus bundle of the LBP engine.
//            gray_*  : pixel read port (addr/req out, ready/data in)
//            lbp_*   : result write port (addr/valid/data out)
//            master  : engine side, slave : memory/system side
// Revision : 1.0 - initial release
// ============================================================================
interface lbp_stream_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic          gray_ready;
    logic [DW-1:0] gray_data;
    logic [AW-1:0] lbp_addr;
    logic          lbp_valid;
    logic [7:0]    lbp_data;

    modport master (
        output gray_addr, gray_req,
        input  gray_ready, gray_data,
        output lbp_addr, lbp_valid, lbp_data
    );

    modport slave (
        input  gray_addr, gray_req,
        output gray_ready, gray_data,
        input  lbp_addr, lbp_valid, lbp_data
    );
endinterface
`default_nettype wire

// File: rtl/lbp_stream_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : lbp_line_buf
// Purpose  : DEPTH-deep, DW-wide delay line. Advances only when shift_en is
//            high, so with DEPTH = image width dout is the pixel exactly one
//            row above the one presented on din.
// Ports    : clk, reset (async, active-high), shift_en, din, dout
// Revision : 1.0 - initial release
// ============================================================================
module lbp_line_buf #(
    parameter int DEPTH = 128,
    parameter int DW    = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          shift_en,
    input  wire logic [DW-1:0] din,
    output logic      [DW-1:0] dout
);
    logic [DW-1:0] tap_q [DEPTH];
    logic [DW-1:0] tap_d [DEPTH];

    always_comb begin
        tap_d = tap_q;
        if (shift_en) begin
            tap_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                tap_d[i] = tap_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            tap_q <= tap_d;
        end
    end

    assign dout = tap_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/lbp_stream.sv
`default_nettype none
// ============================================================================
// Module   : lbp_stream
// Purpose  : Streaming 3x3 Local Binary Pattern engine. Reads each pixel of
//            an IMG_W x IMG_H grey image once in raster order and writes one
//            8-bit code per interior pixel, one clock after the pixel that
//            completes its 3x3 neighbourhood is accepted.
// Ports    : clk, reset (async, active-high)
//            start      - pulse, begins a frame from IDLE/DONE
//            cmp_strict - 0: neighbour>=centre, 1: neighbour>centre
//            finish     - sticky frame-done flag
//            bus        - gray read port + lbp write port (master side)
// Revision : 1.0 - initial release
// ============================================================================
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = 14
) (
    input  wire logic    clk,
    input  wire logic    reset,
    input  wire logic    start,
    input  wire logic    cmp_strict,
    output logic         finish,
    lbp_stream_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t        state_q,     state_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [CW-1:0] col_q,       col_d;
    logic [RW-1:0] row_q,       row_d;
    logic          strict_q,    strict_d;
    logic          finish_q,    finish_d;
    logic          lbp_valid_q, lbp_valid_d;
    logic [AW-1:0] lbp_addr_q,  lbp_addr_d;
    logic [7:0]    lbp_data_q,  lbp_data_d;

    // Window columns: win1 = column c-1, win2 = column c-2 (index 0 top,
    // 1 middle, 2 bottom). The incoming column c comes straight from the
    // line buffers and gray_data, so no extra register stage is needed.
    logic [DW-1:0] win1_q [3];
    logic [DW-1:0] win1_d [3];
    logic [DW-1:0] win2_q [3];
    logic [DW-1:0] win2_d [3];

    logic          w_accept;
    logic          w_last_px;
    logic          w_centre_done;
    logic [DW-1:0] w_above1;
    logic [DW-1:0] w_above2;
    logic [31:0]   w_ctr;
    logic [7:0]    w_code;

    assign w_accept      = (state_q == FETCH) && bus.gray_ready;
    assign w_last_px     = (addr_q == AW'(IMG_W * IMG_H - 1));
    // Columns 0/1 of every row only prime the window, so a centre exists
    // only once both c-1 and c-2 belong to the current row.
    assign w_centre_done = (row_q >= RW'(2)) && (col_q >= CW'(2));

    lbp_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_accept),
        .din      (bus.gray_data),
        .dout     (w_above1)
    );

    lbp_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_accept),
        .din      (w_above1),
        .dout     (w_above2)
    );

    // Eight comparators around the centre (row r-1, column c-1)
    assign w_ctr = 32'(win1_q[1]);

    always_comb begin
        w_code       = '0;
        w_code[B_TL] = nb_bit(32'(win2_q[0]),    w_ctr, strict_q);
        w_code[B_T]  = nb_bit(32'(win1_q[0]),    w_ctr, strict_q);
        w_code[B_TR] = nb_bit(32'(w_above2),     w_ctr, strict_q);
        w_code[B_L]  = nb_bit(32'(win2_q[1]),    w_ctr, strict_q);
        w_code[B_R]  = nb_bit(32'(w_above1),     w_ctr, strict_q);
        w_code[B_BL] = nb_bit(32'(win2_q[2]),    w_ctr, strict_q);
        w_code[B_B]  = nb_bit(32'(win1_q[2]),    w_ctr, strict_q);
        w_code[B_BR] = nb_bit(32'(bus.gray_data), w_ctr, strict_q);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        col_d       = col_q;
        row_d       = row_q;
        strict_d    = strict_q;
        finish_d    = finish_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = FETCH;
                    addr_d   = '0;
                    col_d    = '0;
                    row_d    = '0;
                    finish_d = 1'b0;
                    strict_d = cmp_strict;
                end
            end
            FETCH: begin
                if (w_accept) begin
                    addr_d = addr_q + AW'(1);
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    win2_d = win1_q;
                    win1_d = '{w_above2, w_above1, bus.gray_data};
                    if (w_centre_done) begin
                        lbp_valid_d = 1'b1;
                        lbp_addr_d  = addr_q - AW'(IMG_W + 1);
                        lbp_data_d  = w_code;
                    end
                    if (w_last_px) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d  = DONE;
                finish_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            strict_q    <= 1'b0;
            finish_q    <= 1'b0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                win1_q[i] <= '0;
                win2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            strict_q    <= strict_d;
            finish_q    <= finish_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
        end
    end

    assign bus.gray_req  = (state_q == FETCH);
    assign bus.gray_addr = addr_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign finish        = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbp_stream
// Purpose  : Self-checking bench. Instance A uses the default 128x128 image,
//            instance B a small 8x6 image with random pixels and random
//            gray_ready. Expected codes come from a direct neighbourhood model
//            over the stored image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_stream;
    localparam int W_A = 128, H_A = 128, AW_A = 14;
    localparam int W_B = 8,   H_B = 6,   AW_B = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, strict_a, finish_a;
    logic start_b, strict_b, finish_b;

    lbp_stream_if #(.DW(8), .AW(AW_A)) bus_a ();
    lbp_stream_if #(.DW(8), .AW(AW_B)) bus_b ();

    lbp_stream #(.IMG_W(W_A), .IMG_H(H_A), .DW(8), .AW(AW_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cmp_strict(strict_a),
        .finish(finish_a), .bus(bus_a));

    lbp_stream #(.IMG_W(W_B), .IMG_H(H_B), .DW(8), .AW(AW_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cmp_strict(strict_b),
        .finish(finish_b), .bus(bus_b));

    int tests = 0;
    int fails = 0;
    int img [2][16384];
    int exp0 [$];
    int exp1 [$];
    int pulses [2], first_addr [2], last_addr [2], first_code [2];
    int prev_req [2], prev_addr [2], prev_fin [2], prev_valid [2];
    int rnd_ready [2];
    int dr [8] = '{-1, -1, -1,  0, 0, 1, 1, 1};
    int dc [8] = '{-1,  0,  1, -1, 1,-1, 0, 1};

    function automatic int wof(int id); return (id == 0) ? W_A : W_B; endfunction
    function automatic int hof(int id); return (id == 0) ? H_A : H_B; endfunction
    function automatic int awof(int id); return (id == 0) ? AW_A : AW_B; endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // LBP code straight from the definition: neighbour offsets around (r,c)
    function automatic int model_code(int id, int r, int c, int s);
        int w = wof(id);
        int ctr = img[id][r*w + c];
        int code = 0;
        int n;
        for (int b = 0; b < 8; b++) begin
            n = img[id][(r + dr[b])*w + c + dc[b]];
            if (s != 0 ? (n > ctr) : (n >= ctr)) code |= (1 << b);
        end
        return code;
    endfunction

    function automatic int q_size(int id); return (id == 0) ? exp0.size() : exp1.size(); endfunction
    function automatic int q_pop(int id); return (id == 0) ? exp0.pop_front() : exp1.pop_front(); endfunction
    function automatic void q_clear(int id); if (id == 0) exp0.delete(); else exp1.delete(); endfunction
    function automatic void q_push(int id, int v); if (id == 0) exp0.push_back(v); else exp1.push_back(v); endfunction

    function automatic void build_expected(int id, int s);
        q_clear(id);
        pulses[id] = 0;
        for (int r = 1; r < hof(id) - 1; r++)
            for (int c = 1; c < wof(id) - 1; c++)
                q_push(id, ((r*wof(id) + c) << 8) | model_code(id, r, c, s));
    endfunction

    function automatic int get_addr(int id); return (id == 0) ? int'(bus_a.gray_addr) : int'(bus_b.gray_addr); endfunction
    function automatic int get_fin(int id); return (id == 0) ? int'(finish_a) : int'(finish_b); endfunction
    task automatic set_start(int id, logic v); if (id == 0) start_a = v; else start_b = v; endtask
    task automatic set_strict(int id, logic v); if (id == 0) strict_a = v; else strict_b = v; endtask

    // Per-cycle observation of one instance, sampled 1 time unit after posedge
    task automatic mon(int id, int req, int addr, int ready, int valid, int laddr, int ldata, int fin);
        int e;
        int amask = (1 << awof(id)) - 1;
        if (reset) begin
            check("reset_outputs", req + valid + fin, 0);
            check("reset_gray_addr", addr, 0);
            check("reset_lbp_addr_data", laddr + ldata, 0);
            q_clear(id);
            pulses[id] = 0;
            prev_req[id] = 0; prev_addr[id] = 0; prev_fin[id] = 0; prev_valid[id] = 0;
            return;
        end
        if (prev_req[id] != 0)
            check("gray_addr_step", addr, (ready != 0) ? ((prev_addr[id] + 1) & amask) : prev_addr[id]);
        if (valid != 0) begin
            if (q_size(id) == 0) begin
                check("stale_lbp_valid", valid, 0);
            end else begin
                e = q_pop(id);
                check("lbp_addr", laddr, e >> 8);
                check("lbp_data", ldata, e & 255);
            end
            if (pulses[id] == 0) begin
                first_addr[id] = laddr;
                first_code[id] = ldata;
            end
            last_addr[id] = laddr;
            pulses[id]++;
        end
        if (fin != 0) check("gray_req_while_finish", req, 0);
        if (fin != 0 && prev_fin[id] == 0) begin
            check("pulse_count", pulses[id], (wof(id) - 2) * (hof(id) - 2));
            check("results_outstanding", q_size(id), 0);
            check("finish_after_last_pulse", prev_valid[id], 1);
        end
        prev_req[id] = req; prev_addr[id] = addr; prev_fin[id] = fin; prev_valid[id] = valid;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, int'(bus_a.gray_req), int'(bus_a.gray_addr), int'(bus_a.gray_ready),
                int'(bus_a.lbp_valid), int'(bus_a.lbp_addr), int'(bus_a.lbp_data), int'(finish_a));
            mon(1, int'(bus_b.gray_req), int'(bus_b.gray_addr), int'(bus_b.gray_ready),
                int'(bus_b.lbp_valid), int'(bus_b.lbp_addr), int'(bus_b.lbp_data), int'(finish_b));
        end
    end

    // Grey-image memory model: data for the current address, optional random ready
    initial begin
        forever begin
            @(negedge clk);
            bus_a.gray_ready = (rnd_ready[0] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_a.gray_data  = 8'(img[0][int'(bus_a.gray_addr)]);
            bus_b.gray_ready = (rnd_ready[1] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_b.gray_data  = 8'(img[1][int'(bus_b.gray_addr)]);
        end
    end

    // One frame: start, optional re-start during FETCH, optional abort by reset
    task automatic run_frame(int id, int s, int restart_at, int abort_at);
        int budget = wof(id) * hof(id) * 4 + 100;
        int restarted = 0;
        int aborted = 0;
        build_expected(id, s);
        set_strict(id, 1'(s));
        set_start(id, 1'b1);
        @(negedge clk);
        set_start(id, 1'b0);
        set_strict(id, 1'(~s));
        check("finish_cleared_by_start", get_fin(id), 0);
        for (int k = 0; k < budget; k++) begin
            if (get_fin(id) != 0) break;
            if (restarted == 1) begin
                set_start(id, 1'b0);
                restarted = 2;
            end
            if (restarted == 0 && restart_at >= 0 && get_addr(id) == restart_at) begin
                set_start(id, 1'b1);
                restarted = 1;
            end
            if (abort_at >= 0 && get_addr(id) == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        set_start(id, 1'b0);
        if (aborted == 0) check("finish_seen", get_fin(id), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start_a = 1'b0; strict_a = 1'b0; start_b = 1'b0; strict_b = 1'b0;
        bus_a.gray_ready = 1'b0; bus_a.gray_data = '0;
        bus_b.gray_ready = 1'b0; bus_b.gray_data = '0;
        rnd_ready[0] = 0; rnd_ready[1] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pin the model on hand-computed patterns
        for (int i = 0; i < W_A*H_A; i++) img[0][i] = i % W_A;
        check("model_col_ge", model_code(0, 5, 5, 0), 'hD6);
        check("model_col_gt", model_code(0, 5, 5, 1), 'h94);
        for (int i = 0; i < W_A*H_A; i++) img[0][i] = 100;
        check("model_flat_ge", model_code(0, 7, 9, 0), 'hFF);
        check("model_flat_gt", model_code(0, 7, 9, 1), 'h00);

        // A1: flat image, non-strict -> 15876 codes of 0xFF
        run_frame(0, 0, -1, -1);
        check("A1_first_addr", first_addr[0], 129);
        check("A1_last_addr", last_addr[0], 16254);
        check("A1_first_code", first_code[0], 'hFF);
        check("A1_pulses", pulses[0], 15876);

        // A2: column ramp, strict, aborted by reset at pixel 5000
        for (int i = 0; i < W_A*H_A; i++) img[0][i] = i % W_A;
        run_frame(0, 1, -1, 5000);
        repeat (5) @(negedge clk);
        check("A2_no_finish_after_abort", get_fin(0), 0);

        // A3: column ramp, non-strict, full frame after the abort
        run_frame(0, 0, -1, -1);
        check("A3_first_addr", first_addr[0], 129);
        check("A3_last_addr", last_addr[0], 16254);
        check("A3_first_code", first_code[0], 'hD6);

        // B: random images, ready=1 then random ready on the same image
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W_B*H_B; i++)
                img[1][i] = (f % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            rnd_ready[1] = 0;
            run_frame(1, f % 2, -1, -1);
            check("B_first_addr", first_addr[1], 9);
            check("B_last_addr", last_addr[1], 38);
            check("B_pulses", pulses[1], 24);
            rnd_ready[1] = 1;
            run_frame(1, f % 2, (f == 0) ? 10 : -1, -1);
            check("B_rand_ready_pulses", pulses[1], 24);
            check("B_rand_ready_last_addr", last_addr[1], 38);
        end

        // B: abort mid-frame, then two identical frames back to back
        for (int i = 0; i < W_B*H_B; i++) img[1][i] = int'($urandom_range(0, 7));
        run_frame(1, 0, -1, 20);
        repeat (5) @(negedge clk);
        check("B_no_finish_after_abort", get_fin(1), 0);
        run_frame(1, 1, -1, -1);
        run_frame(1, 1, -1, -1);
        check("B_rerun_pulses", pulses[1], 24);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
